fifo_stream_reader: RTL
=======================

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 SHALL have parameter DWIDTH, default 8, data word width; equals the FIFO's DWIDTH.
REQ-002 SHALL have parameter CNTWIDTH, default 16, width of the delivered-word counter.
REQ-003 SHALL have port rclk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset_L  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port empty  input  1  FIFO read-side empty flag, synchronous to rclk.
REQ-006 SHALL have port pop  output  1  FIFO read request; one word consumed per cycle high.
REQ-007 SHALL have port rdata  input  DWIDTH  FIFO read data; valid only in the cycle after a pop cycle.
REQ-008 SHALL have port flush  input  1  discard all buffered and in-flight words; suppress pop.
REQ-009 SHALL have port m_valid  output  1  downstream stream word available.
REQ-010 SHALL have port m_ready  input  1  downstream accepts word.
REQ-011 SHALL have port m_data  output  DWIDTH  downstream stream data (head of buffer).
REQ-012 SHALL have port rd_count  output  CNTWIDTH  number of words delivered downstream, modulo 2^CNTWIDTH.

Function
REQ-013 SHALL hold a 2-entry output buffer (head/tail, occupancy occ in 0..2) and a 1-bit in-flight flag inf.
REQ-014 SHALL define xfer = m_valid && m_ready; one word leaves the buffer per xfer cycle.
REQ-015 SHALL drive pop = !empty && !flush && (occ + inf - xfer) < 2, combinationally from registered state, empty, flush, and m_ready.
REQ-016 SHALL set inf to 1 at the edge ending a pop cycle, otherwise 0.
REQ-017 SHALL, when inf=1 and flush=0, write rdata into the buffer tail at the edge ending that cycle.
REQ-018 SHALL drive m_valid = (occ != 0) and m_data = head entry, both directly from registers.
REQ-019 SHALL, for a capture and an xfer in the same cycle, leave occ unchanged and preserve word order (FIFO order, no reordering, no duplication).
REQ-020 SHALL hold m_data stable while m_valid=1 and m_ready=0.
REQ-021 SHALL give a latency of 2 cycles: pop in cycle N, word captured at end of N+1, m_valid=1 in N+2.
REQ-022 SHALL sustain one word per cycle when empty=0 and m_ready=1 continuously.
REQ-023 SHALL never let occ exceed 2 nor pop while the buffer cannot absorb the resulting word.
REQ-024 SHALL, on flush=1 at an edge, set occ=0 and inf=0, discarding any rdata in that cycle; xfer in that cycle is still counted.
REQ-025 SHALL increment rd_count by 1 on each xfer; all-ones wraps to 0; not cleared by flush.
REQ-026 SHALL ignore rdata in cycles where inf=0.

Reset
REQ-027 SHALL, while reset_L=0, force occ=0, inf=0, m_valid=0, pop=0, rd_count=0, m_data=0, independent of rclk.
REQ-028 SHALL, on reset assertion mid-operation, drop buffered and in-flight words immediately; first pop is permitted in the first cycle after reset_L rises.

Verification
REQ-029 SHALL cover: FIFO preloaded with 0x11,0x22,0x33, m_ready=1 -> pop high 3 consecutive cycles, m_data 0x11,0x22,0x33 on consecutive cycles starting 2 cycles after first pop, rd_count=3.
REQ-030 SHALL cover: 5 words available, m_ready=0 -> exactly 2 pops, occ=2, m_data=first word held stable; raise m_ready -> remaining 3 words delivered in order, rd_count=5.
REQ-031 SHALL cover: m_ready toggling 1,0,1,0 with continuous data -> no lost or duplicated words; sequence matches FIFO order.
REQ-032 SHALL cover: flush pulsed 1 cycle with occ=2 and inf=1 -> next cycle m_valid=0, no pop during flush, the in-flight word never appears on m_data, rd_count unchanged.
REQ-033 SHALL cover: rd_count at 0xFFFF (CNTWIDTH=16) plus one xfer -> rd_count=0x0000.
REQ-034 SHALL cover: reset_L driven low between clock edges with occ=1 -> m_valid and pop go 0 without a clock edge; after release with empty=0, pop=1 in the first cycle.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
// Pulls words out of a synchronous FIFO read port (one-cycle read latency)
// and presents them as a valid/ready stream. A two-entry skid buffer plus
// an in-flight flag lets it pop every cycle while downstream keeps up.
// Popping stops only when every word already owed could not be absorbed.
// Also counts the words delivered downstream.

module fifo_stream_reader #(
    parameter int DWIDTH   = 8,
    parameter int CNTWIDTH = 16
) (
    input  logic                rclk,
    input  logic                reset_L,
    input  logic                empty,
    output logic                pop,
    input  logic [DWIDTH-1:0]   rdata,
    input  logic                flush,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [DWIDTH-1:0]   m_data,
    output logic [CNTWIDTH-1:0] rd_count
);

    // occ counts buffered words (0..2); inf marks a word arriving on rdata
    // this cycle. occ + inf never exceeds 2, because pop is only raised when
    // the next-cycle total stays below 2.
    logic [1:0]        occ;
    logic              inf;
    logic [DWIDTH-1:0] head;
    logic [DWIDTH-1:0] tail;

    logic              xfer;
    logic              capture;
    logic [1:0]        occ_next;
    logic [1:0]        slot;

    assign m_valid  = (occ != 2'd0);
    assign m_data   = head;
    assign xfer     = m_valid && m_ready;
    assign capture  = inf && !flush;
    // Words that will be held once this cycle's capture and transfer land.
    assign occ_next = occ + {1'b0, inf} - {1'b0, xfer};
    // Buffer position the arriving word lands in, after any shift caused by
    // a transfer. Slot 0 is the head and slot 1 is the tail.
    assign slot     = occ - {1'b0, xfer};
    // A reset in progress must also hold pop low, because the registered
    // state alone would otherwise allow a pop.
    assign pop      = reset_L && !empty && !flush && (occ_next < 2'd2);

    // Buffer occupancy, in-flight tracking and word storage
    always_ff @(posedge rclk or negedge reset_L) begin
        if (!reset_L) begin
            occ  <= 2'd0;
            inf  <= 1'b0;
            head <= '0;
            tail <= '0;
        end else if (flush) begin
            occ  <= 2'd0;
            inf  <= 1'b0;
        end else begin
            inf <= pop;
            occ <= occ_next;
            if (xfer) begin
                head <= tail;
            end
            if (capture) begin
                if (slot == 2'd0) begin
                    head <= rdata;
                end else begin
                    tail <= rdata;
                end
            end
        end
    end

    // Delivered-word counter; it keeps running through flushes
    always_ff @(posedge rclk or negedge reset_L) begin
        if (!reset_L) begin
            rd_count <= '0;
        end else if (xfer) begin
            rd_count <= rd_count + {{(CNTWIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule
